dmem_arbiter: RTL and testbench

- Two-port arbiter in front of the single data memory.
- Port 0 is the core load/store path; port 1 is the debug/loader port used to preload or inspect data memory.
- Grants one request per cycle, drives the memory's write/address/data/mask/load-control inputs, and registers the read data into a one-cycle-later response.
- Port 0 has fixed priority; a saturating wait counter guarantees port 1 forward progress.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_arb_prio.sv | 20 ++
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  localparam int DMEM_WORDS = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b011,
    LHU = 3'b100
  } load_ctrl_e;

  // load_ctrl is kept as raw bits so unsupported codes reach the memory untouched.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [2:0]  load_ctrl;
  } mem_req_t;

endpackage

// File: rtl/dmem_arb_prio.sv
// Combinational grant selector: port 0 has fixed priority unless port 1 is force-granted.
module dmem_arb_prio (
  input  logic [1:0] req_i,
  input  logic       force_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives gnt_o and no latch is inferred.
    gnt_o = 2'b00;
    if (force_i && req_i[1]) begin
      gnt_o = 2'b10;
    end else if (req_i[0]) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one grant per cycle, memory drive, registered one-cycle response.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int WAIT_W    = 3,
  parameter int MEM_WORDS = DMEM_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_mask,
  input  logic [2:0]  m0_load_ctrl,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_mask,
  input  logic [2:0]  m1_load_ctrl,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_wr,
  output logic [3:0]  mem_mask,
  output logic [2:0]  mem_load_ctrl,
  input  logic [31:0] mem_rdata
);

  localparam int              ADDR_LSB   = $clog2(MEM_WORDS) + 2;
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  mem_req_t          m0_r, m1_r, win;
  logic [1:0]        req_v, gnt_v;
  logic              force_c, grant_c, err_c, load_ok_c;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic              m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic [31:0]       m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  assign m0_r = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, mask: m0_mask, load_ctrl: m0_load_ctrl};
  assign m1_r = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, mask: m1_mask, load_ctrl: m1_load_ctrl};

  // Requests are masked while reset is held so nothing is granted or written.
  assign req_v   = {m1_req & rst_n, m0_req & rst_n};
  assign force_c = (wait_cnt_q == MAX_WAIT_C);

  dmem_arb_prio u_prio (
    .req_i   (req_v),
    .force_i (force_c),
    .gnt_o   (gnt_v)
  );

  assign m0_gnt    = gnt_v[0];
  assign m1_gnt    = gnt_v[1];
  assign grant_c   = |gnt_v;
  assign win       = gnt_v[1] ? m1_r : m0_r;
  assign err_c     = |win.addr[31:ADDR_LSB];
  assign load_ok_c = ~win.we & ~err_c;

  always_comb begin
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_data_wr   = '0;
    mem_mask      = '0;
    mem_load_ctrl = '0;
    if (grant_c) begin
      mem_wr        = win.we & ~err_c;
      mem_addr      = win.addr;
      mem_data_wr   = win.wdata;
      mem_mask      = win.mask;
      mem_load_ctrl = win.load_ctrl;
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (req_v[1] && !gnt_v[1]) begin
      wait_cnt_d = force_c ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    end
    m0_rvalid_d = gnt_v[0];
    m0_err_d    = gnt_v[0] & err_c;
    m0_rdata_d  = (gnt_v[0] && load_ok_c) ? mem_rdata : '0;
    m1_rvalid_d = gnt_v[1];
    m1_err_d    = gnt_v[1] & err_c;
    m1_rdata_d  = (gnt_v[1] && load_ok_c) ? mem_rdata : '0;
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m0_err_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rvalid_q <= 1'b0;
      m1_err_q    <= 1'b0;
      m1_rdata_q  <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m0_err_q    <= m0_err_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rvalid_q <= m1_rvalid_d;
      m1_err_q    <= m1_err_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m0_err    = m0_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m1_err    = m1_err_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a small byte-addressed memory stub.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [2:0]  lc;
  } port_t;

  typedef struct {
    string       name;
    port_t       p0;
    port_t       p1;
    logic        g0, g1, wr;
    logic        v0, e0;
    logic [31:0] d0;
    logic        v1, e1;
    logic [31:0] d1;
  } vec_t;

  localparam port_t IDLE = '0;
  localparam logic  H = 1'b1;
  localparam logic  L = 1'b0;
  localparam int    NVEC = 16;

  logic        clk, rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_mask, m1_mask;
  logic [2:0]  m0_load_ctrl, m1_load_ctrl;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_wr;
  logic [31:0] mem_addr, mem_data_wr, mem_rdata;
  logic [3:0]  mem_mask;
  logic [2:0]  mem_load_ctrl;

  int checks = 0;
  int errors = 0;
  vec_t vecs [NVEC];

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_mask(m0_mask), .m0_load_ctrl(m0_load_ctrl), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_mask(m1_mask), .m1_load_ctrl(m1_load_ctrl), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_wr(mem_data_wr),
    .mem_mask(mem_mask), .mem_load_ctrl(mem_load_ctrl), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory stub: byte lanes written at the clock edge, formatted combinational read.
  logic [7:0]  mem_b [0:127];
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_mask[i]) mem_b[{mem_addr[6:2], 2'(i)}] <= mem_data_wr[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = {mem_b[{mem_addr[6:2], 2'd3}], mem_b[{mem_addr[6:2], 2'd2}],
               mem_b[{mem_addr[6:2], 2'd1}], mem_b[{mem_addr[6:2], 2'd0}]};
    rd_byte = rd_word[8*mem_addr[1:0] +: 8];
    rd_half = mem_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (mem_load_ctrl)
      LB:      mem_rdata = {{24{rd_byte[7]}}, rd_byte};
      LH:      mem_rdata = {{16{rd_half[15]}}, rd_half};
      LBU:     mem_rdata = {24'h0, rd_byte};
      LHU:     mem_rdata = {16'h0, rd_half};
      default: mem_rdata = rd_word;
    endcase
  end

  function automatic port_t ld(input logic [31:0] addr, input logic [2:0] lc);
    return '{req: 1'b1, we: 1'b0, addr: addr, wdata: 32'h0, mask: 4'h0, lc: lc};
  endfunction

  function automatic port_t st(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    return '{req: 1'b1, we: 1'b1, addr: addr, wdata: data, mask: mask, lc: LW};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic drive(input port_t p0, input port_t p1);
    m0_req = p0.req; m0_we = p0.we; m0_addr = p0.addr; m0_wdata = p0.wdata;
    m0_mask = p0.mask; m0_load_ctrl = p0.lc;
    m1_req = p1.req; m1_we = p1.we; m1_addr = p1.addr; m1_wdata = p1.wdata;
    m1_mask = p1.mask; m1_load_ctrl = p1.lc;
  endtask

  task automatic check_vec(input vec_t v);
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    exp_addr = v.g0 ? v.p0.addr : (v.g1 ? v.p1.addr : 32'h0);
    exp_data = v.g0 ? v.p0.wdata : (v.g1 ? v.p1.wdata : 32'h0);
    check({v.name, ".m0_gnt"},    32'(m0_gnt),    32'(v.g0));
    check({v.name, ".m1_gnt"},    32'(m1_gnt),    32'(v.g1));
    check({v.name, ".mem_wr"},    32'(mem_wr),    32'(v.wr));
    check({v.name, ".mem_addr"},  mem_addr,       exp_addr);
    check({v.name, ".mem_wdata"}, mem_data_wr,    exp_data);
    check({v.name, ".m0_rvalid"}, 32'(m0_rvalid), 32'(v.v0));
    check({v.name, ".m0_err"},    32'(m0_err),    32'(v.e0));
    check({v.name, ".m0_rdata"},  m0_rdata,       v.d0);
    check({v.name, ".m1_rvalid"}, 32'(m1_rvalid), 32'(v.v1));
    check({v.name, ".m1_err"},    32'(m1_err),    32'(v.e1));
    check({v.name, ".m1_rdata"},  m1_rdata,       v.d1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem_b[i] = 8'h00;

    // Each row is one cycle; response fields belong to the previous row's grant.
    vecs[0]  = '{"sw0",      st(32'h8, 32'hDEADBEEF, 4'hF), IDLE, H, L, H, L, L, 32'h0, L, L, 32'h0};
    vecs[1]  = '{"lw0",      ld(32'h8, LW), IDLE,                 H, L, L, H, L, 32'h0, L, L, 32'h0};
    vecs[2]  = '{"idle0",    IDLE, IDLE,                          L, L, L, H, L, 32'hDEADBEEF, L, L, 32'h0};
    vecs[3]  = '{"sw80",     st(32'h8, 32'h80000000, 4'hF), IDLE, H, L, H, L, L, 32'h0, L, L, 32'h0};
    vecs[4]  = '{"m1_lb",    IDLE, ld(32'hB, LB),                 L, H, L, H, L, 32'h0, L, L, 32'h0};
    vecs[5]  = '{"m1_lbu",   IDLE, ld(32'hB, LBU),                L, H, L, L, L, 32'h0, H, L, 32'hFFFFFF80};
    vecs[6]  = '{"both_lh",  ld(32'hA, LH), ld(32'h8, LHU),       H, L, L, L, L, 32'h0, H, L, 32'h00000080};
    vecs[7]  = '{"m1_lhu",   IDLE, ld(32'h8, LHU),                L, H, L, H, L, 32'hFFFF8000, L, L, 32'h0};
    vecs[8]  = '{"m1_sw",    IDLE, st(32'h0, 32'hCAFEF00D, 4'hF), L, H, H, L, L, 32'h0, H, L, 32'h0};
    vecs[9]  = '{"oob_sw",   st(32'h100, 32'h12345678, 4'hF), IDLE, H, L, L, L, L, 32'h0, H, L, 32'h0};
    vecs[10] = '{"oob_lw",   ld(32'h100, LW), IDLE,               H, L, L, H, H, 32'h0, L, L, 32'h0};
    vecs[11] = '{"m1_oob",   IDLE, ld(32'h80, LW),                L, H, L, H, H, 32'h0, L, L, 32'h0};
    vecs[12] = '{"sw_half",  st(32'h0, 32'h11223344, 4'h3), IDLE, H, L, H, L, L, 32'h0, H, H, 32'h0};
    vecs[13] = '{"lw_chk",   ld(32'h0, LW), IDLE,                 H, L, L, H, L, 32'h0, L, L, 32'h0};
    vecs[14] = '{"idle1",    IDLE, IDLE,                          L, L, L, H, L, 32'hCAFE3344, L, L, 32'h0};
    vecs[15] = '{"idle2",    IDLE, IDLE,                          L, L, L, L, L, 32'h0, L, L, 32'h0};

    // Reset held with a pending store request: nothing may be granted or written.
    rst_n = 1'b0;
    drive(st(32'h8, 32'hDEADBEEF, 4'hF), IDLE);
    repeat (2) @(negedge clk);
    #1;
    check("rst.m0_gnt",    32'(m0_gnt),    32'h0);
    check("rst.m1_gnt",    32'(m1_gnt),    32'h0);
    check("rst.mem_wr",    32'(mem_wr),    32'h0);
    check("rst.rvalid",    {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    check("rst.err",       {30'h0, m1_err, m0_err},       32'h0);
    check("rst.m0_rdata",  m0_rdata,       32'h0);
    check("rst.m1_rdata",  m1_rdata,       32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].p0, vecs[i].p1);
      #1;
      check_vec(vecs[i]);
      @(negedge clk);
    end

    // Both ports requesting continuously: m1 is force-granted every fifth cycle.
    drive(ld(32'h8, LW), ld(32'h0, LW));
    for (int i = 0; i < 12; i++) begin
      #1;
      check($sformatf("fair%0d.m0_gnt", i), 32'(m0_gnt), (i == 4 || i == 9) ? 32'h0 : 32'h1);
      check($sformatf("fair%0d.m1_gnt", i), 32'(m1_gnt), (i == 4 || i == 9) ? 32'h1 : 32'h0);
      @(negedge clk);
    end

    // Asynchronous reset right after an m1 load grant drops the response.
    drive(IDLE, ld(32'h8, LW));
    @(posedge clk);
    #1;
    check("arst.pre_rvalid", 32'(m1_rvalid), 32'h1);
    check("arst.pre_rdata",  m1_rdata,       32'h80000000);
    rst_n = 1'b0;
    #1;
    check("arst.m1_rvalid",  32'(m1_rvalid), 32'h0);
    check("arst.m1_rdata",   m1_rdata,       32'h0);
    check("arst.m1_gnt",     32'(m1_gnt),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(IDLE, IDLE);
    @(negedge clk);
    #1;
    check("arst.no_replay",  32'(m1_rvalid), 32'h0);
    @(negedge clk);

    // Wait counter built up to 3, then reset mid-cycle: it must restart from 0.
    drive(ld(32'h8, LW), ld(32'h0, LW));
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("wrst.m0_gnt",     32'(m0_gnt),    32'h0);
    check("wrst.m0_rvalid",  32'(m0_rvalid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("wrst%0d.m1_gnt", i), 32'(m1_gnt), (i == 4) ? 32'h1 : 32'h0);
      @(negedge clk);
    end
    drive(IDLE, IDLE);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
